// File: rtl/svnet_free_space_fifo_if.sv
// Bundle of the credit-advertised write port and the valid/ready read port of svnet_free_space_fifo.
// The FIFO takes the slave view; whoever writes into it and drains it takes the master view.
interface svnet_free_space_fifo_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  logic [$clog2(DEPTH):0] free_space;
  logic                   write;
  logic [WIDTH-1:0]       write_data;
  logic                   read_valid;
  logic                   read_ready;
  logic [WIDTH-1:0]       read_data;
  logic                   overflow;

  modport master (
    output write, write_data, read_ready,
    input  free_space, read_valid, read_data, overflow
  );

  modport slave (
    input  write, write_data, read_ready,
    output free_space, read_valid, read_data, overflow
  );
endinterface

// File: rtl/svnet_free_space_fifo.sv
// Credit-advertising FWFT FIFO: publishes its exact free entry count and accepts writes against it.
// Optional feature macro SVNET_FREE_SPACE_FIFO_OVERFLOW_EN: drop writes at full and raise sticky overflow.
module svnet_free_space_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  svnet_free_space_fifo_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  cnt_t free_space_q, free_space_d;
  logic read_valid_q, read_valid_d;

  logic full;
  logic wr_en;
  logic rd_en;

  // Acceptance looks only at registered state: a read at full frees its slot next cycle, not now.
  assign full  = (count_q == DEPTH_C);
  assign wr_en = bus.write && !full;
  assign rd_en = read_valid_q && bus.read_ready;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    free_space_d = DEPTH_C - count_d;
    read_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      free_space_q <= DEPTH_C;
      read_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      free_space_q <= free_space_d;
      read_valid_q <= read_valid_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the reset pointers and count make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= bus.write_data;
  end

  assign bus.free_space = free_space_q;
  assign bus.read_valid = read_valid_q;
  assign bus.read_data  = mem_q[rd_ptr_q];

`ifdef SVNET_FREE_SPACE_FIFO_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // A write arriving with no credit is dropped by the wr_en gate and remembered until reset.
  assign overflow_d = overflow_q || (bus.write && full);

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;

  a_no_write_without_credit : assert property (
    @(posedge clk) disable iff (rst) bus.write |-> (free_space_q != '0)
  ) else $error("write issued with zero free_space");
`endif

  a_count_in_range : assert property (
    @(posedge clk) disable iff (rst) count_q <= DEPTH_C
  ) else $error("count exceeded DEPTH");

endmodule

// File: tb/tb_svnet_free_space_fifo.sv
// Self-checking bench for svnet_free_space_fifo: directed table, corner sequences, then random traffic
// compared against a queue-based model of the FIFO.
module tb_svnet_free_space_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
`ifdef SVNET_FREE_SPACE_FIFO_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  svnet_free_space_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  svnet_free_space_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: contents as a plain queue, credit is whatever room is left.
  logic [7:0] mq [$];
  bit         m_ovf = 1'b0;

  task automatic model_step(input bit r, input bit w, input logic [7:0] d, input bit rdy);
    bit pop;
    bit push;
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      push = w && (mq.size() < DEPTH);
      if (w && mq.size() == DEPTH) m_ovf = OVF_EN;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(d);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rdy);
    rst             = r;
    bus.write       = w;
    bus.write_data  = d;
    bus.read_ready  = rdy;
    model_step(r, w, d, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".free_space"}, 32'(bus.free_space), 32'(DEPTH - mq.size()));
    check({tag, ".read_valid"}, 32'(bus.read_valid), 32'(mq.size() != 0));
    check({tag, ".overflow"},   32'(bus.overflow),   32'(m_ovf));
    if (mq.size() != 0) check({tag, ".read_data"}, 32'(bus.read_data), 32'(mq[0]));
  endtask

  typedef struct {
    bit         rst;
    bit         wr;
    logic [7:0] data;
    bit         rdy;
    int         exp_free;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input bit r, input bit w, input logic [7:0] d, input bit rdy,
                         input int ef, input bit ev, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.wr = w; v.data = d; v.rdy = rdy;
    v.exp_free = ef; v.exp_valid = ev; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  task automatic run_random(input int cycles);
    bit         r;
    bit         w;
    bit         rdy;
    logic [7:0] d;
    for (int c = 0; c < cycles; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      w   = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 1) == 1);
      d   = 8'($urandom);
      if (!OVF_EN && mq.size() == DEPTH) w = 1'b0;
      step(r, w, d, rdy);
      compare_model("rand");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] heads [4];

    bus.write      = 1'b0;
    bus.write_data = '0;
    bus.read_ready = 1'b0;

    //      rst  wr  data   rdy  free valid data
    add_vec(1'b1, 1'b0, 8'h00, 1'b0, 4, 1'b0, 8'h00);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b0, 8'h00);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b0, 8'h00);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b0, 8'h00);
    add_vec(1'b0, 1'b1, 8'h11, 1'b0, 3, 1'b1, 8'h11);
    add_vec(1'b0, 1'b1, 8'h22, 1'b0, 2, 1'b1, 8'h11);
    add_vec(1'b0, 1'b1, 8'h33, 1'b0, 1, 1'b1, 8'h11);
    add_vec(1'b0, 1'b1, 8'h44, 1'b0, 0, 1'b1, 8'h11);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h22);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h33);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b1, 8'h44);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 4, 1'b0, 8'h00);
    add_vec(1'b0, 1'b0, 8'h00, 1'b1, 4, 1'b0, 8'h00);
    add_vec(1'b0, 1'b1, 8'h77, 1'b1, 3, 1'b1, 8'h77);
    add_vec(1'b0, 1'b1, 8'h88, 1'b0, 2, 1'b1, 8'h77);
    add_vec(1'b0, 1'b1, 8'h99, 1'b0, 1, 1'b1, 8'h77);
    add_vec(1'b1, 1'b1, 8'hAA, 1'b0, 4, 1'b0, 8'h00);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4, 1'b0, 8'h00);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].data, vecs[i].rdy);
      check($sformatf("vec%0d.free_space", i), 32'(bus.free_space), 32'(vecs[i].exp_free));
      check($sformatf("vec%0d.read_valid", i), 32'(bus.read_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d.overflow", i),   32'(bus.overflow),   32'(0));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d.read_data", i), 32'(bus.read_data), 32'(vecs[i].exp_data));
      compare_model($sformatf("vec%0d.model", i));
    end

    // Two words resident, then write and read together for ten cycles across the pointer wrap.
    step(1'b0, 1'b1, 8'h50, 1'b0);
    step(1'b0, 1'b1, 8'h51, 1'b0);
    check("conc.prefill.free_space", 32'(bus.free_space), 32'(2));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'(8'h52 + i), 1'b1);
      check($sformatf("conc%0d.free_space", i), 32'(bus.free_space), 32'(2));
      check($sformatf("conc%0d.read_data", i),  32'(bus.read_data),  32'(8'(8'h51 + i)));
      compare_model($sformatf("conc%0d.model", i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("conc.drain1.free_space", 32'(bus.free_space), 32'(3));
    check("conc.drain1.read_data",  32'(bus.read_data),  32'(8'h5B));
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("conc.drain2.free_space", 32'(bus.free_space), 32'(4));
    check("conc.drain2.read_valid", 32'(bus.read_valid), 32'(0));

    // Fill to full, then read at full: credit returns only on the following cycle.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
      check($sformatf("fill%0d.free_space", i), 32'(bus.free_space), 32'(3 - i));
    end
    if (OVF_EN) step(1'b0, 1'b1, 8'h66, 1'b1);
    else        step(1'b0, 1'b0, 8'h00, 1'b1);
    check("full_rd.free_space", 32'(bus.free_space), 32'(1));
    check("full_rd.overflow",   32'(bus.overflow),   32'(OVF_EN));
    check("full_rd.read_data",  32'(bus.read_data),  32'(8'h61));
    step(1'b0, 1'b1, 8'h67, 1'b0);
    check("credit_reuse.free_space", 32'(bus.free_space), 32'(0));
    heads[0] = 8'h62; heads[1] = 8'h63; heads[2] = 8'h67; heads[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("drain%0d.free_space", i), 32'(bus.free_space), 32'(i + 1));
      if (i < 3) check($sformatf("drain%0d.read_data", i), 32'(bus.read_data), 32'(heads[i]));
      else       check("drain3.read_valid", 32'(bus.read_valid), 32'(0));
      compare_model($sformatf("drain%0d.model", i));
    end
    check("sticky.overflow", 32'(bus.overflow), 32'(OVF_EN));
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("ovf_reset.overflow", 32'(bus.overflow), 32'(0));

    run_random(400);

    step(1'b0, 1'b0, 8'h00, 1'b0);
    compare_model("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
